spi_regfile_peripheral: RTL and testbench
=========================================

SPI_REGFILE_PERIPHERAL -- requirements
Module: spi_regfile_peripheral

Interface
REQ-001 The block SHALL take parameter NUM_REGS, default 5, number of writable/readable registers (1..128).
REQ-002 The block SHALL take parameter DATA_W, default 8, register and data-phase width in bits (8 or 16).
REQ-003 The block SHALL take parameter ADDR_W, default 7, address-field width in bits.
REQ-004 The block SHALL take parameter CPOL, default 0, SCLK idle level; CPHA is fixed at 0.
REQ-005 The block SHALL have port clk, input, 1, system clock; all logic is in this domain.
REQ-006 The block SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-007 The block SHALL have port SCLK, input, 1, SPI clock, asynchronous to clk.
REQ-008 The block SHALL have port nCS, input, 1, SPI chip select, active-low, asynchronous.
REQ-009 The block SHALL have port COPI, input, 1, controller-out data.
REQ-010 The block SHALL have port CIPO, output, 1, peripheral-out data.
REQ-011 The block SHALL have port cipo_oe, output, 1, CIPO output enable, high only while the synchronised nCS is low.
REQ-012 The block SHALL have port regs_flat, output, NUM_REGS*DATA_W, register contents, register i at bits [i*DATA_W +: DATA_W].
REQ-013 The block SHALL have port wr_strobe, output, 1, one-clk pulse on each register commit.
REQ-014 The block SHALL have port wr_addr, output, ADDR_W, address of the last commit, valid with wr_strobe.
REQ-015 The block SHALL have port err_count, output, 8, saturating count of malformed frames.

Function
REQ-016 SCLK, nCS and COPI SHALL each pass through a 2-flop synchroniser; edges SHALL be detected on the synchronised values.
REQ-017 Frame format, MSB first: bit R/W (1 = write, 0 = read), then ADDR_W address bits, then DATA_W data bits; FRAME_LEN = 1+ADDR_W+DATA_W.
REQ-018 COPI SHALL be sampled on the leading SCLK edge (rising if CPOL=0, falling if CPOL=1) while synchronised nCS is low.
REQ-019 The bit counter SHALL saturate at FRAME_LEN+1; further sampling edges SHALL not shift data.
REQ-020 A synchronised nCS falling edge SHALL clear the counter and shift register; this takes priority over a coincident SCLK edge.
REQ-021 State machine: IDLE (nCS high) -> ADDR (nCS falls) -> DATA (counter reaches 1+ADDR_W) -> DONE (counter reaches FRAME_LEN) -> IDLE (nCS rises). A nCS rise in any state SHALL return the machine to IDLE.
REQ-022 On entry to DATA with R/W=0, the addressed register SHALL be loaded into a DATA_W output shifter; an address >= NUM_REGS SHALL load all zeros.
REQ-023 CIPO SHALL present the shifter MSB and update on each trailing SCLK edge in DATA; in all other states CIPO SHALL be 0.
REQ-024 Write commit SHALL occur one clk after a synchronised nCS rising edge, only if R/W=1, counter == FRAME_LEN and address < NUM_REGS; wr_strobe SHALL pulse in that same cycle.
REQ-025 A write with an out-of-range address SHALL be ignored silently, without strobe or error.
REQ-026 At a nCS rise with counter != FRAME_LEN (short or long frame), the frame SHALL be discarded and err_count SHALL increment, saturating at 255.
REQ-027 A read frame SHALL never modify any register or pulse wr_strobe.

Reset
REQ-028 While rst_n is low, all registers, synchronisers (to the idle levels nCS=1, SCLK=CPOL), counter, shifters and err_count SHALL be 0 except as stated, state SHALL be IDLE, and wr_strobe, CIPO and cipo_oe SHALL be 0.
REQ-029 When reset is asserted mid-frame, the partial frame SHALL be dropped, with no commit and no error count.

Structure
REQ-030 A shared package spi_pkg SHALL hold the state enum and the localparam FRAME_LEN function.
REQ-031 The synchroniser and edge detector SHALL be one sub-module, spi_sync_edge, instantiated three times.

Verification
REQ-032 Scenario: default parameters, CPOL=0, write frame 1_0000100_0x80 -> regs_flat[39:32]=0x80, one wr_strobe, wr_addr=4.
REQ-033 Scenario: read frame 0_0000010 after register 2 was written 0xA5 -> CIPO bits 1,0,1,0,0,1,0,1 over the data phase, with registers unchanged.
REQ-034 Scenario: 12-bit write frame, then nCS rises -> no register change, err_count=1; repeat 300 times -> err_count=255.
REQ-035 Scenario: write to address 0x7F -> no strobe, err_count unchanged; a subsequent read of 0x7F returns 0x00.
REQ-036 Scenario: DATA_W=16, CPOL=1, write 0x1234 to register 0 -> regs_flat[15:0]=0x1234.
REQ-037 Scenario: rst_n pulsed low after bit 10 of a write -> all outputs 0, and the next full frame commits normally.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI register-file peripheral: frame-phase states
// and the frame length helper.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } spi_state_e;

  function automatic int frame_len(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for one asynchronous SPI pin, with rise/fall pulses
// derived from the synchronised value.
module spi_sync_edge #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Reset to the pin's idle level so leaving reset never fakes an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
      prev_q <= RESET_VAL;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync_o = sync_q;
  assign rise_o = sync_q & ~prev_q;
  assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/spi_regfile_peripheral.sv
// SPI (mode CPHA=0) peripheral exposing NUM_REGS registers: R/W bit, address,
// then data, MSB first; writes commit after chip select is released.
module spi_regfile_peripheral
  import spi_pkg::*;
#(
  parameter int   NUM_REGS = 5,
  parameter int   DATA_W   = 8,
  parameter int   ADDR_W   = 7,
  parameter logic CPOL     = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       SCLK,
  input  logic                       nCS,
  input  logic                       COPI,
  output logic                       CIPO,
  output logic                       cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0] regs_flat,
  output logic                       wr_strobe,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic [7:0]                 err_count
);

  localparam int FRAME_LEN = frame_len(ADDR_W, DATA_W);
  localparam int CNT_W     = $clog2(FRAME_LEN + 2);
  localparam logic [CNT_W-1:0] CNT_HDR  = CNT_W'(1 + ADDR_W);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_LEN + 1);

  logic sclk_s, sclk_rise, sclk_fall;
  logic ncs_s, ncs_rise, ncs_fall;
  logic copi_s, copi_rise, copi_fall;

  spi_sync_edge #(.RESET_VAL(CPOL)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .async_i(SCLK),
    .sync_o(sclk_s), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );

  spi_sync_edge #(.RESET_VAL(1'b1)) u_sync_ncs (
    .clk(clk), .rst_n(rst_n), .async_i(nCS),
    .sync_o(ncs_s), .rise_o(ncs_rise), .fall_o(ncs_fall)
  );

  spi_sync_edge #(.RESET_VAL(1'b0)) u_sync_copi (
    .clk(clk), .rst_n(rst_n), .async_i(COPI),
    .sync_o(copi_s), .rise_o(copi_rise), .fall_o(copi_fall)
  );

  logic unused_sync;
  assign unused_sync = ^{sclk_s, copi_rise, copi_fall};

  spi_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [FRAME_LEN-1:0]  shift_q, shift_d;
  logic [DATA_W-1:0]     out_q, out_d;
  logic                  cipo_q, cipo_d;
  logic [DATA_W-1:0]     regs_q [NUM_REGS];
  logic                  wr_strobe_q;
  logic [ADDR_W-1:0]     wr_addr_q;
  logic [7:0]            err_q;

  logic lead_edge, trail_edge, sample;
  assign lead_edge  = CPOL ? sclk_fall : sclk_rise;
  assign trail_edge = CPOL ? sclk_rise : sclk_fall;
  assign sample     = lead_edge & ~ncs_s & ~ncs_fall;

  // Header fields are valid once 1+ADDR_W bits are in; frame fields at FRAME_LEN.
  logic              hdr_rw;
  logic [ADDR_W-1:0] hdr_addr;
  logic              frm_rw;
  logic [ADDR_W-1:0] frm_addr;
  logic [DATA_W-1:0] frm_data;
  assign hdr_rw   = shift_q[ADDR_W];
  assign hdr_addr = shift_q[ADDR_W-1:0];
  assign frm_rw   = shift_q[FRAME_LEN-1];
  assign frm_addr = shift_q[FRAME_LEN-2 -: ADDR_W];
  assign frm_data = shift_q[DATA_W-1:0];

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return 32'(a) < 32'(NUM_REGS);
  endfunction

  logic [DATA_W-1:0] rd_data;
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (32'(hdr_addr) == 32'(i)) rd_data = regs_q[i];
    end
  end

  logic commit, frame_err;
  assign commit    = ncs_rise && (cnt_q == CNT_FULL) && frm_rw && in_range(frm_addr);
  assign frame_err = ncs_rise && (cnt_q != CNT_FULL);

  // Chip-select edges override everything; otherwise shift bits and walk the phases.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    out_d   = out_q;
    cipo_d  = cipo_q;
    if (ncs_fall) begin
      state_d = ST_ADDR;
      cnt_d   = '0;
      shift_d = '0;
      out_d   = '0;
      cipo_d  = 1'b0;
    end else if (ncs_rise) begin
      state_d = ST_IDLE;
      cipo_d  = 1'b0;
    end else begin
      if (sample && (cnt_q != CNT_SAT)) begin
        cnt_d   = cnt_q + CNT_W'(1);
        shift_d = {shift_q[FRAME_LEN-2:0], copi_s};
      end
      case (state_q)
        ST_ADDR: begin
          if (cnt_q == CNT_HDR) begin
            state_d = ST_DATA;
            out_d   = hdr_rw ? '0 : rd_data;
          end
        end
        ST_DATA: begin
          if (cnt_q == CNT_FULL) begin
            state_d = ST_DONE;
          end else if (trail_edge) begin
            cipo_d = out_q[DATA_W-1];
            out_d  = {out_q[DATA_W-2:0], 1'b0};
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      out_q   <= '0;
      cipo_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      out_q   <= out_d;
      cipo_q  <= cipo_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      err_q       <= '0;
    end else begin
      wr_strobe_q <= commit;
      if (commit) begin
        wr_addr_q <= frm_addr;
        for (int i = 0; i < NUM_REGS; i++) begin
          if (32'(frm_addr) == 32'(i)) regs_q[i] <= frm_data;
        end
      end
      if (frame_err && (err_q != 8'hFF)) err_q <= err_q + 8'd1;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_flat[g*DATA_W +: DATA_W] = regs_q[g];
  end

  assign CIPO      = (state_q == ST_DATA) ? cipo_q : 1'b0;
  assign cipo_oe   = ~ncs_s;
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_spi_regfile_peripheral.sv
// Scoreboard bench: two peripherals (8-bit/CPOL0 and 16-bit/CPOL1) driven by
// random and directed SPI frames, checked against an array-based register model.
module tb_spi_regfile_peripheral;

  localparam int NUM_REGS = 5;
  localparam int ADDR_W   = 7;
  localparam int DW_A     = 8;
  localparam int DW_B     = 16;
  localparam int LEN_A    = 1 + ADDR_W + DW_A;
  localparam int LEN_B    = 1 + ADDR_W + DW_B;
  localparam int HALF     = 5;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic                     sclkA, ncsA, copiA, cipoA, oeA, wrStrobeA;
  logic [NUM_REGS*DW_A-1:0] regsA;
  logic [ADDR_W-1:0]        wrAddrA;
  logic [7:0]               errA;

  logic                     sclkB, ncsB, copiB, cipoB, oeB, wrStrobeB;
  logic [NUM_REGS*DW_B-1:0] regsB;
  logic [ADDR_W-1:0]        wrAddrB;
  logic [7:0]               errB;

  spi_regfile_peripheral #(.NUM_REGS(NUM_REGS), .DATA_W(DW_A), .ADDR_W(ADDR_W), .CPOL(1'b0)) dutA (
    .clk(clk), .rst_n(rst_n), .SCLK(sclkA), .nCS(ncsA), .COPI(copiA), .CIPO(cipoA),
    .cipo_oe(oeA), .regs_flat(regsA), .wr_strobe(wrStrobeA), .wr_addr(wrAddrA), .err_count(errA)
  );

  spi_regfile_peripheral #(.NUM_REGS(NUM_REGS), .DATA_W(DW_B), .ADDR_W(ADDR_W), .CPOL(1'b1)) dutB (
    .clk(clk), .rst_n(rst_n), .SCLK(sclkB), .nCS(ncsB), .COPI(copiB), .CIPO(cipoB),
    .cipo_oe(oeB), .regs_flat(regsB), .wr_strobe(wrStrobeB), .wr_addr(wrAddrB), .err_count(errB)
  );

  typedef struct {
    int addr;
    int data;
  } wr_t;

  wr_t wrQA[$];
  wr_t wrQB[$];
  int  readQA[$];
  int  modelA[NUM_REGS];
  int  modelB[NUM_REGS];
  int  errModelA;
  int  errModelB;
  int  checks = 0;
  int  passes = 0;

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic setPins(input int bus, input logic s, input logic n, input logic c);
    if (bus == 0) begin
      sclkA = s; ncsA = n; copiA = c;
    end else begin
      sclkB = s; ncsB = n; copiB = c;
    end
  endtask

  // Bit-bang one frame (MSB first) with CPHA=0 timing; optionally leave nCS low.
  task automatic applyStimulus(input int bus, input logic [31:0] word, input int nbits, input bit raiseCs);
    logic idle;
    idle = (bus == 0) ? 1'b0 : 1'b1;
    setPins(bus, idle, 1'b0, 1'b0);
    clks(2 * HALF);
    for (int i = nbits - 1; i >= 0; i--) begin
      setPins(bus, idle, 1'b0, word[i]);
      clks(HALF);
      setPins(bus, ~idle, 1'b0, word[i]);
      clks(HALF);
    end
    setPins(bus, idle, 1'b0, 1'b0);
    clks(HALF);
    if (raiseCs) begin
      setPins(bus, idle, 1'b1, 1'b0);
      clks(3 * HALF);
    end
  endtask

  function automatic logic [31:0] mkA(input int rw, input int addr, input int data);
    logic [31:0] w;
    w = '0;
    w[15] = rw[0];
    w[14:8] = addr[6:0];
    w[7:0] = data[7:0];
    return w;
  endfunction

  function automatic logic [31:0] mkB(input int rw, input int addr, input int data);
    logic [31:0] w;
    w = '0;
    w[23] = rw[0];
    w[22:16] = addr[6:0];
    w[15:0] = data[15:0];
    return w;
  endfunction

  // Reference behaviour: whole frames only; anything else is an error.
  task automatic modelFrame(input int bus, input logic [31:0] word, input int nbits);
    int dw, len, rw, addr, data;
    dw = (bus == 0) ? DW_A : DW_B;
    len = 1 + ADDR_W + dw;
    if (nbits != len) begin
      if (bus == 0) errModelA = (errModelA < 255) ? errModelA + 1 : 255;
      else errModelB = (errModelB < 255) ? errModelB + 1 : 255;
      return;
    end
    rw = int'(word[len-1]);
    addr = int'((word >> dw) & 32'd127);
    data = int'(word & ((32'd1 << dw) - 32'd1));
    if (rw == 1) begin
      if (addr < NUM_REGS) begin
        if (bus == 0) begin
          modelA[addr] = data;
          wrQA.push_back('{addr: addr, data: data});
        end else begin
          modelB[addr] = data;
          wrQB.push_back('{addr: addr, data: data});
        end
      end
    end else if (bus == 0) begin
      readQA.push_back((addr < NUM_REGS) ? modelA[addr] : 0);
    end
  endtask

  task automatic doFrame(input int bus, input logic [31:0] word, input int nbits);
    modelFrame(bus, word, nbits);
    applyStimulus(bus, word, nbits, 1'b1);
  endtask

  task automatic checkRegsA(input string tag);
    for (int i = 0; i < NUM_REGS; i++)
      checkOutput($sformatf("%s_regA%0d", tag, i), regsA[i*DW_A +: DW_A], modelA[i]);
    checkOutput({tag, "_errA"}, errA, errModelA);
  endtask

  initial begin : strobeMonitorA
    wr_t e;
    forever begin
      @(negedge clk);
      if (wrStrobeA === 1'b1) begin
        if (wrQA.size() == 0) begin
          checks++;
          $display("[TB] FAIL strobeA_unexpected: wr_addr=%0d, required no strobe", wrAddrA);
        end else begin
          e = wrQA.pop_front();
          checkOutput("wr_addrA", wrAddrA, e.addr);
          checkOutput("commit_dataA", regsA[e.addr*DW_A +: DW_A], e.data);
        end
      end
    end
  end

  initial begin : strobeMonitorB
    wr_t e;
    forever begin
      @(negedge clk);
      if (wrStrobeB === 1'b1) begin
        if (wrQB.size() == 0) begin
          checks++;
          $display("[TB] FAIL strobeB_unexpected: wr_addr=%0d, required no strobe", wrAddrB);
        end else begin
          e = wrQB.pop_front();
          checkOutput("wr_addrB", wrAddrB, e.addr);
          checkOutput("commit_dataB", regsB[e.addr*DW_B +: DW_B], e.data);
        end
      end
    end
  end

  // Bus-side monitor: captures CIPO at every leading edge of a complete read frame.
  initial begin : readMonitorA
    int idx, rdata, hdrOnes, oeLow;
    logic rw;
    idx = 0; rdata = 0; hdrOnes = 0; oeLow = 0; rw = 1'b1;
    forever begin
      @(posedge sclkA or posedge ncsA);
      if (ncsA === 1'b1) begin
        if (idx == LEN_A && rw == 1'b0) begin
          if (readQA.size() == 0) begin
            checks++;
            $display("[TB] FAIL read_unexpected: data=0x%0h, required no read", rdata);
          end else begin
            checkOutput("read_dataA", rdata, readQA.pop_front());
            checkOutput("cipo_in_header", hdrOnes, 0);
            checkOutput("oe_low_in_frame", oeLow, 0);
          end
        end
        idx = 0; rdata = 0; hdrOnes = 0; oeLow = 0; rw = 1'b1;
      end else begin
        if (idx == 0) rw = copiA;
        if (idx <= ADDR_W) hdrOnes += int'(cipoA);
        else rdata = (rdata << 1) | int'(cipoA);
        if (oeA !== 1'b1) oeLow++;
        idx++;
      end
    end
  end

  initial begin : mainStimulus
    int kind, nb;
    sclkA = 1'b0; ncsA = 1'b1; copiA = 1'b0;
    sclkB = 1'b1; ncsB = 1'b1; copiB = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      modelA[i] = 0;
      modelB[i] = 0;
    end
    errModelA = 0; errModelB = 0;
    rst_n = 1'b0;
    clks(5);
    checkOutput("reset_regsA", regsA, 0);
    checkOutput("reset_errA", errA, 0);
    checkOutput("reset_strobeA", wrStrobeA, 0);
    checkOutput("reset_wraddrA", wrAddrA, 0);
    checkOutput("reset_cipoA", cipoA, 0);
    checkOutput("reset_oeA", oeA, 0);
    checkOutput("reset_regsB", regsB, 0);
    rst_n = 1'b1;
    clks(5);

    doFrame(0, mkA(1, 4, 'h80), LEN_A);
    checkOutput("write_reg4", regsA[39:32], 'h80);

    doFrame(0, mkA(1, 2, 'hA5), LEN_A);
    doFrame(0, mkA(0, 2, 'h00), LEN_A);
    checkRegsA("after_read2");

    doFrame(0, mkA(1, 'h7F, 'h3C), LEN_A);
    checkOutput("oor_write_err", errA, 0);
    doFrame(0, mkA(0, 'h7F, 'h00), LEN_A);

    for (int n = 0; n < 40; n++) begin
      kind = int'($urandom_range(0, 4));
      case (kind)
        0, 1: doFrame(0, mkA(1, int'($urandom_range(0, NUM_REGS - 1)), int'($urandom)), LEN_A);
        2: doFrame(0, mkA(0, int'($urandom_range(0, 7)), int'($urandom)), LEN_A);
        3: doFrame(0, mkA(1, int'($urandom_range(NUM_REGS, 127)), int'($urandom)), LEN_A);
        default: begin
          nb = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 15)) : int'($urandom_range(17, 20));
          doFrame(0, $urandom, nb);
        end
      endcase
    end
    checkRegsA("after_random");

    doFrame(1, mkB(1, 0, 'h1234), LEN_B);
    checkOutput("cpol1_reg0", regsB[15:0], 'h1234);
    for (int n = 0; n < 4; n++)
      doFrame(1, mkB(1, int'($urandom_range(1, NUM_REGS - 1)), int'($urandom)), LEN_B);
    doFrame(1, mkB(1, 1, 'hBEEF) >> 3, LEN_B - 3);
    for (int i = 0; i < NUM_REGS; i++)
      checkOutput($sformatf("regB%0d", i), regsB[i*DW_B +: DW_B], modelB[i]);
    checkOutput("errB", errB, errModelB);

    // Reset in the middle of a write: nothing may commit or count.
    applyStimulus(0, mkA(1, 3, 'h77) >> 6, 10, 1'b0);
    rst_n = 1'b0;
    setPins(0, 1'b0, 1'b1, 1'b0);
    clks(3);
    checkOutput("midreset_regsA", regsA, 0);
    checkOutput("midreset_errA", errA, 0);
    checkOutput("midreset_strobeA", wrStrobeA, 0);
    checkOutput("midreset_cipoA", cipoA, 0);
    checkOutput("midreset_oeA", oeA, 0);
    for (int i = 0; i < NUM_REGS; i++) begin
      modelA[i] = 0;
      modelB[i] = 0;
    end
    errModelA = 0; errModelB = 0;
    clks(3);
    rst_n = 1'b1;
    clks(5);
    doFrame(0, mkA(1, 3, 'h77), LEN_A);
    checkOutput("post_reset_reg3", regsA[31:24], 'h77);
    checkOutput("post_reset_err", errA, 0);

    doFrame(0, mkA(1, 1, 'hFF) >> 4, 12);
    checkOutput("short_frame_err1", errA, 1);
    checkRegsA("after_short");
    for (int n = 0; n < 299; n++) doFrame(0, mkA(1, 1, 'hFF) >> 4, 12);
    checkOutput("short_frame_err_sat", errA, 255);
    checkRegsA("after_sat");

    clks(10);
    checkOutput("pending_writesA", wrQA.size(), 0);
    checkOutput("pending_writesB", wrQB.size(), 0);
    checkOutput("pending_readsA", readQA.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
